// File: rtl/logic_unit_arbiter.sv
// Two-requester front end for a shared 8-bit bitwise logic unit.
// Round-robin grant, one operation per three cycles: IDLE -> EXEC -> RESP.
module logic_unit_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] o,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NOTA = 2'b11
    } op_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       winner_q, winner_d;
    logic [1:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] o_q, o_d;

    // NOTE: every variable gets a hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        o_d      = o_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // With both asking, the one not served last time wins.
                    winner_d = (req0 && req1) ? ~last_q : req1;
                    op_d     = winner_d ? op1 : op0;
                    a_d      = winner_d ? a1  : a0;
                    b_d      = winner_d ? b1  : b0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                unique case (op_t'(op_q))
                    OP_AND:  o_d = a_q & b_q;
                    OP_OR:   o_d = a_q | b_q;
                    OP_XOR:  o_d = a_q ^ b_q;
                    OP_NOTA: o_d = ~a_q;
                endcase
                state_d = RESP;
            end
            RESP: begin
                last_d  = winner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            winner_q <= 1'b0;
            op_q     <= 2'b00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            o_q      <= 8'h00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            o_q      <= o_d;
        end
    end

    // Pulses decode straight from state, so each lasts exactly one cycle and reset clears them at once.
    always_comb begin
        gnt0  = (state_q == EXEC) && !winner_q;
        gnt1  = (state_q == EXEC) &&  winner_q;
        done0 = (state_q == RESP) && !winner_q;
        done1 = (state_q == RESP) &&  winner_q;
        busy  = (state_q != IDLE);
        o     = o_q;
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: hand-computed results, grant order,
// pulse timing, reset abort and idle hold.
module tb_logic_unit_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] o;

    int errors = 0;
    int checks = 0;

    logic_unit_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .op0   (op0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .op1   (op1),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .o     (o),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulses(input string tag, input logic [3:0] exp);
        check(tag, {gnt0, gnt1, done0, done1}, {28'd0, exp});
    endtask

    // One isolated request: grant next cycle, done the cycle after, then idle.
    // Operands and opcode are disturbed during EXEC to confirm they were latched.
    task automatic do_op(input string tag, input int id, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        if (id == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else         begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        step();
        check({tag, "_gnt"}, {gnt0, gnt1, done0, done1}, (id == 0) ? 32'b1000 : 32'b0100);
        check({tag, "_busy_exec"}, busy, 1'b1);
        if (id == 0) begin req0 = 1'b0; op0 = ~op; a0 = 8'hFF; b0 = ~b; end
        else         begin req1 = 1'b0; op1 = ~op; a1 = 8'hFF; b1 = ~b; end
        step();
        check({tag, "_done"}, {gnt0, gnt1, done0, done1}, (id == 0) ? 32'b0010 : 32'b0001);
        check({tag, "_o"}, o, exp);
        step();
        check({tag, "_idle"}, {busy, gnt0, gnt1, done0, done1}, 32'd0);
        check({tag, "_hold"}, o, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; op0 = 2'b00; a0 = 8'h00; b0 = 8'h00;
        req1 = 1'b0; op1 = 2'b00; a1 = 8'h00; b1 = 8'h00;
        #2;
        check("reset_o", o, 8'h00);
        check("reset_busy", busy, 1'b0);
        check_pulses("reset_pulses", 4'b0000);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single request on requester 0.
        do_op("single_and", 0, 2'b00, 8'hAA, 8'hFF, 8'hAA);

        // Opcode sweep on requester 1.
        do_op("r1_and",  1, 2'b00, 8'hF0, 8'h3C, 8'h30);
        do_op("r1_or",   1, 2'b01, 8'hF0, 8'h3C, 8'hFC);
        do_op("r1_xor",  1, 2'b10, 8'hF0, 8'h3C, 8'hCC);
        do_op("r1_nota", 1, 2'b11, 8'hF0, 8'h3C, 8'h0F);

        // Operand change after capture (A0 forced to FF during EXEC).
        do_op("late_change", 0, 2'b01, 8'h0F, 8'h00, 8'h0F);

        // Contention straight out of reset: 0 wins first, then strict alternation.
        rst_n = 1'b0;
        #1;
        check("rst2_o", o, 8'h00);
        step();
        rst_n = 1'b1;
        req0 = 1'b1; op0 = 2'b10; a0 = 8'h5A; b0 = 8'hFF;
        req1 = 1'b1; op1 = 2'b01; a1 = 8'h0F; b1 = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("cont%0d_gnt", i), {gnt0, gnt1, done0, done1},
                  (i % 2 == 0) ? 32'b1000 : 32'b0100);
            step();
            check($sformatf("cont%0d_done", i), {gnt0, gnt1, done0, done1},
                  (i % 2 == 0) ? 32'b0010 : 32'b0001);
            check($sformatf("cont%0d_o", i), o, (i % 2 == 0) ? 8'hA5 : 8'hFF);
            step();
            check($sformatf("cont%0d_idle", i), busy, 1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();

        // Reset during EXEC aborts the operation.
        req0 = 1'b1; op0 = 2'b00; a0 = 8'h3C; b0 = 8'hFF;
        step();
        check("abort_exec_busy", busy, 1'b1);
        check("abort_exec_gnt0", gnt0, 1'b1);
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        check("abort_o", o, 8'h00);
        check("abort_busy", busy, 1'b0);
        check_pulses("abort_pulses", 4'b0000);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("abort_after%0d", i), {busy, gnt0, gnt1, done0, done1}, 32'd0);
            check($sformatf("abort_after%0d_o", i), o, 8'h00);
        end
        do_op("post_abort", 1, 2'b00, 8'h55, 8'hFF, 8'h55);

        // Idle hold: nothing requested, result and outputs stay put.
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("idle%0d_o", i), o, 8'h55);
            check($sformatf("idle%0d_ctl", i), {busy, gnt0, gnt1, done0, done1}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
